// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divide/remainder unit.
// Radix-2 restoring divider, one quotient bit per cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             sel_rem;
    logic             neg_q;
    logic             neg_r;
    logic             spec;

    logic             accept;
    logic             last;
    logic             s1;
    logic             s2;
    logic             div0;
    logic             ovf;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] spec_res;
    logic [WIDTH:0]   pr;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fin;

    // Operand conditioning and one restoring-division step
    always_comb begin
        accept   = start && !busy;
        last     = spec || (cnt == CW'(WIDTH-1));
        s1       = !op[0] && data1[WIDTH-1];
        s2       = !op[0] && data2[WIDTH-1];
        a_abs    = s1 ? -data1 : data1;
        b_abs    = s2 ? -data2 : data2;
        div0     = (data2 == ZERO);
        ovf      = !op[0] && (data1 == SMIN) && (data2 == ONES);
        spec_res = ZERO;
        if (div0)
            spec_res = op[1] ? data1 : ONES;
        else if (ovf)
            spec_res = op[1] ? ZERO : SMIN;
        pr    = {rem, dvd[WIDTH-1]};
        diff  = pr - {1'b0, dvs};
        ge    = (pr >= {1'b0, dvs});
        rem_n = ge ? diff[WIDTH-1:0] : pr[WIDTH-1:0];
        quo_n = {dvd[WIDTH-2:0], ge};
        q_fix = neg_q ? -quo_n : quo_n;
        r_fix = neg_r ? -rem_n : rem_n;
        fin   = spec ? dvd : (sel_rem ? r_fix : q_fix);
    end

    // Next-state logic; flush overrides accept and completion
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = CALC;
            CALC: if (last) state_n = DONE;
            DONE: state_n = start ? CALC : IDLE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    // State register with registered busy and valid pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= (state_n == CALC);
            result_valid <= (state == CALC) && (state_n == DONE);
        end
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            spec    <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            sel_rem <= op[1];
            neg_q   <= s1 ^ s2;
            neg_r   <= s1;
            spec    <= div0 || ovf;
            dvd     <= (div0 || ovf) ? spec_res : a_abs;
            dvs     <= b_abs;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (!spec) begin
                rem <= rem_n;
                dvd <= quo_n;
            end
            if (last)
                result <= fin;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency,
// flush, ignored start, back-to-back issue and async reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .data1        (data1),
        .data2        (data2),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Wait for result_valid; returns cycles counted after accept
    task automatic wait_valid(output int cyc, input bit poke);
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 5) begin
                start = 1'b1;
                op    = DIVU;
                data1 = 32'd100;
                data2 = 32'd1;
            end else if (poke && cyc == 6) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input bit poke);
        int cyc;
        start = 1'b1;
        op    = o;
        data1 = a;
        data2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_valid(cyc, poke);
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = DIV;
        data1   = '0;
        data2   = '0;
        flush   = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, 0);
        run("rem_7_m2", REM, 32'd7, 32'hFFFFFFFE, 32'd1, 32, 0);
        run("rem_m7_2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0);

        // Back-to-back: start held, second operands presented while busy
        start = 1'b1;
        op    = DIVU;
        data1 = 32'hFFFFFFFF;
        data2 = 32'd1;
        @(posedge clk);
        #1;
        op    = REMU;
        data1 = 32'd100;
        data2 = 32'd7;
        wait_valid(cyc, 0);
        chk("b2b1_lat", cyc, 32);
        chk("b2b1_res", result, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b2_busy", {31'd0, busy}, 32'd1);
        chk("b2b1_pulse", {31'd0, result_valid}, 32'd0);
        wait_valid(cyc, 0);
        chk("b2b2_lat", cyc, 32);
        chk("b2b2_res", result, 32'd2);
        @(posedge clk);
        #1;

        run("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        run("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        run("ovf_div", DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 1, 0);
        run("ovf_rem", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
        run("ovf_divu", DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32, 0);
        run("rem_m5_0", REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 0);

        // Flush at the 10th CALC edge
        start = 1'b1;
        op    = DIV;
        data1 = 32'd100;
        data2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_valid", {31'd0, result_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid === 1'b1) seen++;
        end
        chk("fl_novalid", seen, 0);
        chk("fl_result", result, 32'hFFFFFFFB);

        run("div_9_3", DIV, 32'd9, 32'd3, 32'd3, 32, 1);

        // Async reset between edges mid-CALC
        start = 1'b1;
        op    = DIVU;
        data1 = 32'd50;
        data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_valid", {31'd0, result_valid}, 32'd0);
        chk("ar_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run("divu_10_3", DIVU, 32'd10, 32'd3, 32'd3, 32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
